// File: rtl/top_tx_mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// top_tx_mul_arbiter_if
// Bundles the request and result channels of the shared TX multiplier
// arbiter.
//   req_valid / req_ready : per-requester valid/ready handshake (NUM_REQ bits)
//   req_din0 / req_din1   : packed operands, requester i at [i*W +: W]
//   out_valid / out_ready : result handshake toward downstream
//   out_dout / out_id     : truncated product and its requester tag
//   busy                  : result held or any request pending
//   out_ovf               : product overflow flag (TOP_TX_MUL_ARBITER_OVF_EN)
// Modports: slave = arbiter side, master = requester/downstream side.
// ---------------------------------------------------------------------------
interface top_tx_mul_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 3,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 13,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic                          out_valid;
  logic                          out_ready;
  logic [DOUT_WIDTH-1:0]         out_dout;
  logic [ID_WIDTH-1:0]           out_id;
  logic                          busy;
`ifdef TOP_TX_MUL_ARBITER_OVF_EN
  logic                          out_ovf;

  modport slave (
    input  req_valid, req_din0, req_din1, out_ready,
    output req_ready, out_valid, out_dout, out_id, busy, out_ovf
  );

  modport master (
    output req_valid, req_din0, req_din1, out_ready,
    input  req_ready, out_valid, out_dout, out_id, busy, out_ovf
  );
`else
  modport slave (
    input  req_valid, req_din0, req_din1, out_ready,
    output req_ready, out_valid, out_dout, out_id, busy
  );

  modport master (
    output req_valid, req_din0, req_din1, out_ready,
    input  req_ready, out_valid, out_dout, out_id, busy
  );
`endif
endinterface

// File: rtl/top_tx_mul_arbiter.sv
// ---------------------------------------------------------------------------
// top_tx_mul_arbiter
// Shares one unsigned DIN0_WIDTH x DIN1_WIDTH multiplier between NUM_REQ
// TX requesters. A combinational round-robin grant selects one requester
// per cycle; the truncated product is captured in a single output register
// with backpressure and tagged with the winning requester index.
// Ports:
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset
//   bus      : top_tx_mul_arbiter_if.slave (request and result channels)
// Optional feature macro: TOP_TX_MUL_ARBITER_OVF_EN adds a registered
// out_ovf flag, set when the full product does not fit in DOUT_WIDTH bits.
// ---------------------------------------------------------------------------
module top_tx_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 3,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 13,
  parameter int ID_WIDTH   = 2
) (
  input logic                  ap_clk,
  input logic                  ap_rst_n,
  top_tx_mul_arbiter_if.slave  bus
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
  localparam int PTR_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  out_state_e                state_r;
  out_state_e                state_nxt_s;
  logic [PTR_WIDTH-1:0]      rr_ptr_r;
  logic [DOUT_WIDTH-1:0]     out_dout_r;
  logic [ID_WIDTH-1:0]       out_id_r;

  logic                      accept_en_s;
  logic                      grant_found_s;
  logic [PTR_WIDTH-1:0]      grant_idx_s;
  logic [PTR_WIDTH:0]        cand_s;
  logic [NUM_REQ-1:0]        ready_s;
  logic                      xfer_s;
  logic [DIN0_WIDTH-1:0]     din0_sel_s;
  logic [DIN1_WIDTH-1:0]     din1_sel_s;
  logic [PROD_WIDTH-1:0]     prod_s;

  // Full-width unsigned product; truncation happens at the register.
  function automatic logic [PROD_WIDTH-1:0] mul_full(
    input logic [DIN0_WIDTH-1:0] a,
    input logic [DIN1_WIDTH-1:0] b
  );
    mul_full = PROD_WIDTH'(a) * PROD_WIDTH'(b);
  endfunction

`ifdef TOP_TX_MUL_ARBITER_OVF_EN
  logic out_ovf_r;

  // Any product bit at or above DOUT_WIDTH means the result was truncated.
  function automatic logic prod_ovf(input logic [PROD_WIDTH-1:0] p);
    prod_ovf = ((p >> DOUT_WIDTH) != '0);
  endfunction
`endif

  assign accept_en_s = (state_r == ST_EMPTY) || bus.out_ready;

  // Round-robin search starting at rr_ptr_r and wrapping to 0.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (PTR_WIDTH+1)'(k);
      if (cand_s >= (PTR_WIDTH+1)'(NUM_REQ)) begin
        cand_s = cand_s - (PTR_WIDTH+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && bus.req_valid[cand_s[PTR_WIDTH-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[PTR_WIDTH-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot ready; forced low while reset is asserted.
  always_comb begin
    ready_s = '0;
    if (ap_rst_n && accept_en_s && grant_found_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s = |(bus.req_valid & ready_s);

  // Operand mux for the granted requester.
  always_comb begin
    din0_sel_s = '0;
    din1_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_WIDTH'(i) == grant_idx_s) begin
        din0_sel_s = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        din1_sel_s = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
      end else begin
        din0_sel_s = din0_sel_s;
        din1_sel_s = din1_sel_s;
      end
    end
  end

  assign prod_s = mul_full(din0_sel_s, din1_sel_s);

  // Output register next-state: EMPTY/FULL with back-to-back refill.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (xfer_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_s) begin
          state_nxt_s = ST_FULL;
        end else if (bus.out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Output state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result, tag and priority pointer; only a transfer updates them.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_dout_r <= '0;
      out_id_r   <= '0;
      rr_ptr_r   <= '0;
    end else if (xfer_s) begin
      out_dout_r <= prod_s[DOUT_WIDTH-1:0];
      out_id_r   <= ID_WIDTH'(grant_idx_s);
      if (grant_idx_s == PTR_WIDTH'(NUM_REQ - 1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= grant_idx_s + PTR_WIDTH'(1);
      end
    end else begin
      out_dout_r <= out_dout_r;
      out_id_r   <= out_id_r;
      rr_ptr_r   <= rr_ptr_r;
    end
  end

`ifdef TOP_TX_MUL_ARBITER_OVF_EN
  // Overflow flag travels with the result it describes.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_ovf_r <= 1'b0;
    end else if (xfer_s) begin
      out_ovf_r <= prod_ovf(prod_s);
    end else begin
      out_ovf_r <= out_ovf_r;
    end
  end

  assign bus.out_ovf = out_ovf_r;
`endif

  assign bus.req_ready = ready_s;
  assign bus.out_valid = (state_r == ST_FULL);
  assign bus.out_dout  = out_dout_r;
  assign bus.out_id    = out_id_r;
  assign bus.busy      = (state_r == ST_FULL) || (|bus.req_valid);

endmodule

// File: tb/tb_top_tx_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_top_tx_mul_arbiter
// Directed bench for top_tx_mul_arbiter with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_top_tx_mul_arbiter;

  logic ap_clk;
  logic ap_rst_n;
  int   vectors;
  int   miscompares;

  top_tx_mul_arbiter_if #(
    .NUM_REQ(4), .DIN0_WIDTH(3), .DIN1_WIDTH(12), .DOUT_WIDTH(13), .ID_WIDTH(2)
  ) bus ();

  top_tx_mul_arbiter #(
    .NUM_REQ(4), .DIN0_WIDTH(3), .DIN1_WIDTH(12), .DOUT_WIDTH(13), .ID_WIDTH(2)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [2:0] a, input logic [11:0] b);
    bus.req_din0[i*3 +: 3]  = a;
    bus.req_din1[i*12 +: 12] = b;
  endtask

  logic [31:0] exp_prod [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    ap_rst_n      = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_ready", bus.req_ready, 32'd0);
    check("rst_valid", bus.out_valid, 32'd0);
    check("rst_dout", bus.out_dout, 32'd0);
    check("rst_id", bus.out_id, 32'd0);
    bus.req_valid = 4'b0000;
    ap_rst_n = 1'b1;
    #1;
    check("idle_busy", bus.busy, 32'd0);

    // Single requester 0: 5*100
    set_ops(0, 3'd5, 12'd100);
    bus.req_valid = 4'b0001;
    #1;
    check("single_ready", bus.req_ready, 32'd1);
    tick();
    bus.req_valid = 4'b0000;
    check("single_valid", bus.out_valid, 32'd1);
    check("single_dout", bus.out_dout, 32'd500);
    check("single_id", bus.out_id, 32'd0);

    // Single requester 3 moves rr back to 0: 3*7
    set_ops(3, 3'd3, 12'd7);
    bus.req_valid = 4'b1000;
    #1;
    check("r3_ready", bus.req_ready, 32'd8);
    tick();
    check("r3_dout", bus.out_dout, 32'd21);
    check("r3_id", bus.out_id, 32'd3);

    // All four continuously valid from rr=0
    exp_prod[0] = 32'd10;
    exp_prod[1] = 32'd40;
    exp_prod[2] = 32'd90;
    exp_prod[3] = 32'd160;
    set_ops(0, 3'd1, 12'd10);
    set_ops(1, 3'd2, 12'd20);
    set_ops(2, 3'd3, 12'd30);
    set_ops(3, 3'd4, 12'd40);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", bus.req_ready, 32'd1 << (k % 4));
      tick();
      check("rr_valid", bus.out_valid, 32'd1);
      check("rr_id", bus.out_id, 32'(k % 4));
      check("rr_dout", bus.out_dout, exp_prod[k % 4]);
    end

    // Backpressure: result for requester 0 held, rr stays at 1
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", bus.req_ready, 32'd0);
      tick();
      check("bp_valid", bus.out_valid, 32'd1);
      check("bp_id", bus.out_id, 32'd0);
      check("bp_dout", bus.out_dout, 32'd10);
      check("bp_busy", bus.busy, 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.req_ready, 32'd2);
    tick();
    check("bp_release_id", bus.out_id, 32'd1);
    check("bp_release_dout", bus.out_dout, 32'd40);

    // Truncation: 7*4095 = 28665 -> 4089 (rr=2)
    set_ops(2, 3'd7, 12'd4095);
    bus.req_valid = 4'b0100;
    #1;
    check("trunc_ready", bus.req_ready, 32'd4);
    tick();
    check("trunc_dout", bus.out_dout, 32'd4089);
    check("trunc_id", bus.out_id, 32'd2);
`ifdef TOP_TX_MUL_ARBITER_OVF_EN
    check("trunc_ovf", bus.out_ovf, 32'd1);
`endif
    set_ops(2, 3'd1, 12'd4095);
    #1;
    check("fit_ready", bus.req_ready, 32'd4);
    tick();
    check("fit_dout", bus.out_dout, 32'd4095);
`ifdef TOP_TX_MUL_ARBITER_OVF_EN
    check("fit_ovf", bus.out_ovf, 32'd0);
`endif

    // Wrap: rr=3, requesters 3 and 0 alternate
    set_ops(0, 3'd5, 12'd100);
    set_ops(3, 3'd4, 12'd40);
    bus.req_valid = 4'b1001;
    #1;
    check("wrap_ready_a", bus.req_ready, 32'd8);
    tick();
    check("wrap_id_a", bus.out_id, 32'd3);
    check("wrap_dout_a", bus.out_dout, 32'd160);
    #1;
    check("wrap_ready_b", bus.req_ready, 32'd1);
    tick();
    check("wrap_id_b", bus.out_id, 32'd0);
    check("wrap_dout_b", bus.out_dout, 32'd500);
    #1;
    check("wrap_ready_c", bus.req_ready, 32'd8);
    tick();
    check("wrap_id_c", bus.out_id, 32'd3);

    // Drain
    bus.req_valid = 4'b0000;
    tick();
    check("drain_valid", bus.out_valid, 32'd0);
    check("drain_busy", bus.busy, 32'd0);

    // Async reset while a result is held under backpressure (rr=0 -> grant 1, rr=2)
    set_ops(1, 3'd2, 12'd20);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    check("pre_rst_valid", bus.out_valid, 32'd1);
    check("pre_rst_id", bus.out_id, 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 32'd0);
    check("async_rst_dout", bus.out_dout, 32'd0);
    check("async_rst_id", bus.out_id, 32'd0);
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    ap_rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.req_ready, 32'd1);
    tick();
    check("post_rst_id", bus.out_id, 32'd0);
    check("post_rst_dout", bus.out_dout, 32'd500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/top_tx_mul_arbiter.md
Name: top_tx_mul_arbiter

Overview:
- Shares one unsigned 3-bit x 12-bit -> 13-bit multiplier between NUM_REQ requesters in the TX datapath.
- Round-robin arbitration on valid/ready request channels.
- One registered output stage with backpressure; each result is tagged with the index of the requester that issued it.
- Sits between the TX per-lane scaling stages and the shared multiplier resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIN0_WIDTH, 3, unsigned operand A width.
- DIN1_WIDTH, 12, unsigned operand B width.
- DOUT_WIDTH, 13, result width; product truncated to these LSBs.
- ID_WIDTH, 2, width of requester tag; must be >= clog2(NUM_REQ).

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_din0  in  NUM_REQ*DIN0_WIDTH  packed operand A; requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH].
- req_din1  in  NUM_REQ*DIN1_WIDTH  packed operand B, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_dout  out  DOUT_WIDTH  product.
- out_id  out  ID_WIDTH  index of the requester that produced out_dout.
- busy  out  1  high when out_valid=1 or any req_valid=1.

Behaviour:
- Reset: ap_clk single domain; ap_rst_n asynchronous active-low.
  - On reset: out_valid=0, out_dout=0, out_id=0, rr pointer=0, req_ready=0.
  - Reset mid-transfer discards the held result; no partial output.
- Output register states:
  - EMPTY (out_valid=0) -> FULL on accept.
  - FULL -> EMPTY when out_ready=1 and no new accept.
  - FULL -> FULL when out_ready=1 and a new accept occurs (back-to-back, one result per cycle).
  - FULL held while out_ready=0; out_dout and out_id stable.
- accept_en = !out_valid || out_ready (combinational).
- Grant is combinational round-robin:
  - Search starts at rr pointer, wraps NUM_REQ-1 -> 0.
  - First requester with req_valid=1 wins.
  - req_ready[g] = accept_en && req_valid[g]; all other ready bits are 0.
- On a transfer (req_valid[g] && req_ready[g]):
  - out_dout <= (din0_g * din1_g) mod 2^DOUT_WIDTH, unsigned, full product formed at DIN0_WIDTH+DIN1_WIDTH bits before truncation.
  - out_id <= g; out_valid <= 1; rr pointer <= (g+1) mod NUM_REQ.
- Latency: one cycle from accepted request to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- No transfer means rr pointer unchanged; stall never advances priority.
- Requester rule: once req_valid is asserted, the requester holds it and its operands until req_ready. The block tolerates data changes while not granted and samples only on a transfer.
- Starvation bound: a continuously valid requester is granted within NUM_REQ transfers.
- Single requester active: it is granted every accept_en cycle.
- No req_valid: req_ready=0, state unchanged except output drain.

Optional Feature:
- Macro: TOP_TX_MUL_ARBITER_OVF_EN.
- When defined:
  - Adds output port out_ovf (1 bit), registered alongside out_dout.
  - out_ovf=1 when the full product has any nonzero bit at or above DOUT_WIDTH.
  - Reset value 0; held with out_dout under backpressure.
- When undefined: port absent, no overflow logic.

Test Plan:
- Reset, then single requester: req_valid=0001, din0=5, din1=100 -> req_ready=0001 that cycle; next cycle out_valid=1, out_dout=500, out_id=0.
- All four valid continuously, out_ready=1, rr=0 -> grants 0,1,2,3,0,... one per cycle; out_id follows 0,1,2,3 with one-cycle lag.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0, out_dout/out_id stable, rr unchanged; on out_ready=1 the next grant goes to the pending rr index.
- Truncation: din0=7, din1=4095 -> full 28665 (0x6FF9); out_dout=0x0FF9=4089; with TOP_TX_MUL_ARBITER_OVF_EN, out_ovf=1. din0=1, din1=4095 -> 4095, out_ovf=0.
- Wrap/fairness: rr=3, req_valid=1001 -> grant 3, then grant 0, then grant 3.
- Async reset asserted while out_valid=1, out_ready=0 -> out_valid drops immediately without a clock edge; after release the first grant goes to requester 0.
